gol_run_ctrl: RTL and testbench

Generation sequencer for the toroidal N×N Game of Life grid. It captures a seed pattern, asks the grid to load it, then advances the grid one generation at a time. After each generation it inspects the grid's `cells` vector and stops on one of these conditions: extinction, still life, generation limit, or (optionally) a period-2 oscillation. It sits between the host/test logic and a step-enabled grid wrapper; the grid evolves only when this block pulses `grid_step`.

---
 rtl/gol_pkg.sv | 21 ++
 rtl/gol_pattern_detect.sv | 25 ++
 rtl/gol_run_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_gol_run_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types for the Game of Life run controller: sequencer states and
// the status codes reported when a run stops.
package gol_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_PAUSED = 3'd5,
    ST_DONE   = 3'd6
  } gol_state_e;

  localparam logic [2:0] GOL_ST_NONE    = 3'd0;
  localparam logic [2:0] GOL_ST_LIMIT   = 3'd1;
  localparam logic [2:0] GOL_ST_EXTINCT = 3'd2;
  localparam logic [2:0] GOL_ST_STILL   = 3'd3;
  localparam logic [2:0] GOL_ST_OSC2    = 3'd4;

endpackage

// File: rtl/gol_pattern_detect.sv
// Combinational pattern checks on the grid cell vector.
// The two-generations-back compare exists only when GOL_OSC2_EN is defined.
module gol_pattern_detect #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] cells,
  input  logic [W-1:0] prev,
  input  logic [W-1:0] prev2,
  output logic         is_empty,
  output logic         eq_prev,
  output logic         eq_prev2
);

  assign is_empty = (cells == '0);
  assign eq_prev  = (cells == prev);

`ifdef GOL_OSC2_EN
  assign eq_prev2 = (cells == prev2);
`else
  logic unused_prev2;
  assign unused_prev2 = ^prev2;
  assign eq_prev2     = 1'b0;
`endif

endmodule

// File: rtl/gol_run_ctrl.sv
// Generation sequencer for the toroidal Game of Life grid: load seed, step,
// inspect, stop. Define GOL_OSC2_EN to add period-2 oscillation detection.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | grid_load pulse, grid takes grid_seeds
// SETTLE | one cycle for cells to show the loaded pattern
// STEP   | grid_step pulse, history captured, generation counted
// CHECK  | evaluate stop conditions on the current cells
// PAUSED | parked between generations until single_step or pause release
// DONE   | run finished, status/gen_count/grid_seeds held
module gol_run_ctrl
  import gol_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned GEN_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic               single_step,
  input  logic [GEN_W-1:0]   gen_limit,
  input  logic [N*N-1:0]     seeds,
  input  logic [N*N-1:0]     cells,
  output logic [N*N-1:0]     grid_seeds,
  output logic               grid_load,
  output logic               grid_step,
  output logic [GEN_W-1:0]   gen_count,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status
);

  localparam int unsigned W = N * N;
  localparam logic [GEN_W-1:0] GEN_ONE = {{(GEN_W-1){1'b0}}, 1'b1};

  gol_state_e       state_q, state_d;
  logic [W-1:0]     seeds_q, seeds_d;
  logic [GEN_W-1:0] limit_q, limit_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [2:0]       status_q, status_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic             load_q, load_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     prev2_w;

`ifdef GOL_OSC2_EN
  logic [W-1:0]     prev2_q, prev2_d;
  logic             prev2_valid_q, prev2_valid_d;
  assign prev2_w = prev2_q;
`else
  assign prev2_w = '0;
`endif

  logic is_empty, eq_prev, eq_prev2;

  gol_pattern_detect #(.W(W)) u_detect (
    .cells    (cells),
    .prev     (prev_q),
    .prev2    (prev2_w),
    .is_empty (is_empty),
    .eq_prev  (eq_prev),
    .eq_prev2 (eq_prev2)
  );

`ifndef GOL_OSC2_EN
  logic unused_eq_prev2;
  assign unused_eq_prev2 = eq_prev2;
`endif

  always_comb begin
    state_d      = state_q;
    seeds_d      = seeds_q;
    limit_d      = limit_q;
    gen_d        = gen_q;
    status_d     = status_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`ifdef GOL_OSC2_EN
    prev2_d       = prev2_q;
    prev2_valid_d = prev2_valid_q;
`endif

    if (abort) begin
      state_d  = ST_IDLE;
      status_d = GOL_ST_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            seeds_d      = seeds;
            limit_d      = gen_limit;
            gen_d        = '0;
            status_d     = GOL_ST_NONE;
            prev_valid_d = 1'b0;
`ifdef GOL_OSC2_EN
            prev2_valid_d = 1'b0;
`endif
            state_d      = ST_LOAD;
          end
        end
        ST_LOAD:   state_d = ST_SETTLE;
        ST_SETTLE: state_d = ST_CHECK;
        ST_STEP: begin
          // cells still shows the pre-step generation at this edge
          prev_d       = cells;
          prev_valid_d = 1'b1;
`ifdef GOL_OSC2_EN
          prev2_d       = prev_q;
          prev2_valid_d = prev_valid_q;
`endif
          gen_d        = gen_q + GEN_ONE;
          state_d      = ST_CHECK;
        end
        ST_CHECK: begin
          if (is_empty) begin
            state_d  = ST_DONE;
            status_d = GOL_ST_EXTINCT;
          end else if (prev_valid_q && eq_prev) begin
            state_d  = ST_DONE;
            status_d = GOL_ST_STILL;
`ifdef GOL_OSC2_EN
          end else if (prev2_valid_q && eq_prev2) begin
            state_d  = ST_DONE;
            status_d = GOL_ST_OSC2;
`endif
          end else if (gen_q == limit_q) begin
            state_d  = ST_DONE;
            status_d = GOL_ST_LIMIT;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_STEP;
          end
        end
        ST_PAUSED: begin
          if (single_step || !pause) state_d = ST_STEP;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are flopped from the next state so they line up with state_q.
    load_d = (state_d == ST_LOAD);
    step_d = (state_d == ST_STEP);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_LOAD)  || (state_d == ST_SETTLE) ||
             (state_d == ST_STEP)  || (state_d == ST_CHECK)  ||
             (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      seeds_q      <= '0;
      limit_q      <= '0;
      gen_q        <= '0;
      status_q     <= GOL_ST_NONE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      load_q       <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seeds_q      <= seeds_d;
      limit_q      <= limit_d;
      gen_q        <= gen_d;
      status_q     <= status_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      load_q       <= load_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef GOL_OSC2_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prev2_q       <= '0;
      prev2_valid_q <= 1'b0;
    end else begin
      prev2_q       <= prev2_d;
      prev2_valid_q <= prev2_valid_d;
    end
  end
`endif

  assign grid_seeds = seeds_q;
  assign grid_load  = load_q;
  assign grid_step  = step_q;
  assign gen_count  = gen_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_gol_run_ctrl.sv
// Self-checking bench for gol_run_ctrl: behavioural 4x4 toroidal grid, a
// generation-level run predictor and a per-cycle timeline compare.
module tb_gol_run_ctrl;

`ifdef GOL_OSC2_EN
  localparam bit OSC = 1'b1;
`else
  localparam bit OSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, pause = 1'b0, single_step = 1'b0;
  logic [15:0] gen_limit = '0;
  logic [15:0] seeds = '0;
  logic [15:0] cells = '0;
  logic [15:0] grid_seeds;
  logic        grid_load, grid_step;
  logic [15:0] gen_count;
  logic        busy, done;
  logic [2:0]  status;

  int checks = 0;
  int errors = 0;
  int step_pulses = 0;

  bit          model_on = 1'b0;
  int          k = 0;
  int          mG = 0, mS = 0;
  logic [15:0] mSeed = '0;

  gol_run_ctrl #(.N(4), .GEN_W(16)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .single_step (single_step),
    .gen_limit   (gen_limit),
    .seeds       (seeds),
    .cells       (cells),
    .grid_seeds  (grid_seeds),
    .grid_load   (grid_load),
    .grid_step   (grid_step),
    .gen_count   (gen_count),
    .busy        (busy),
    .done        (done),
    .status      (status)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] life(input logic [15:0] c);
    logic [15:0] r;
    int n;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        n = 0;
        for (int di = -1; di <= 1; di++)
          for (int dj = -1; dj <= 1; dj++)
            if (di != 0 || dj != 0)
              n += int'(c[((i + di + 4) % 4) * 4 + ((j + dj + 4) % 4)]);
        r[i*4+j] = (n == 3) || (c[i*4+j] && n == 2);
      end
    return r;
  endfunction

  // Whole-run prediction: final generation and stop reason.
  task automatic predict(input logic [15:0] sd, input int lim, output int g, output int s);
    logic [15:0] cur, p1, p2;
    int rec;
    cur = sd; p1 = '0; p2 = '0; g = 0; rec = 0; s = 0;
    while (s == 0) begin
      if (cur == 16'h0)                       s = 2;
      else if (rec >= 1 && cur == p1)         s = 3;
      else if (OSC && rec >= 2 && cur == p2)  s = 4;
      else if (g == lim)                      s = 1;
      else begin
        p2 = p1; p1 = cur; cur = life(cur); g++; rec++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Grid wrapper stand-in.
  always @(posedge clk) begin
    if (grid_load)      cells <= grid_seeds;
    else if (grid_step) cells <= life(cells);
    if (grid_step) step_pulses <= step_pulses + 1;
  end

  // Timeline after the start edge: cycle 1 LOAD, 2 SETTLE, 3+2g CHECK at
  // generation g, 2+2g STEP into generation g, DONE after cycle 3+2G.
  always @(negedge clk) begin
    if (model_on) begin
      int t;
      k++;
      t = 3 + 2 * mG;
      chk("load",   grid_load, k == 1);
      chk("busy",   busy, k <= t);
      chk("done",   done, k > t);
      chk("step",   grid_step, (k >= 4) && (k <= t) && (k % 2 == 0));
      chk("gen",    gen_count, (k > t) ? mG : ((k >= 3) ? (k - 3) / 2 : 0));
      chk("status", status, (k > t) ? mS : 0);
      chk("seeds",  grid_seeds, mSeed);
    end
  end

  task automatic run_model(input logic [15:0] sd, input int lim, input bit poke);
    int g, s, t, sp0;
    predict(sd, lim, g, s);
    t = 3 + 2 * g;
    @(negedge clk);
    sp0 = step_pulses;
    seeds = sd; gen_limit = lim[15:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mG = g; mS = s; mSeed = sd; k = 0; model_on = 1'b1;
    seeds = 16'($urandom); gen_limit = 16'($urandom);
    for (int i = 0; i < t + 3; i++) begin
      @(negedge clk);
      start = poke && (i + 1 < t) && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    model_on = 1'b0;
    chk("step_count", step_pulses - sp0, g);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_timeout", done, 1);
  endtask

  initial begin
    int g, s, sp0, ab, eg;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", grid_load, 0);
    chk("rst_step", grid_step, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_status", status, 0);
    chk("rst_seeds", grid_seeds, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Pin the predictor to hand-worked results.
    predict(16'h0033, 10, g, s); chk("pin_block_g", g, 1);  chk("pin_block_s", s, 3);
    predict(16'h0001, 10, g, s); chk("pin_lone_g", g, 1);   chk("pin_lone_s", s, 2);
    predict(16'h0000, 10, g, s); chk("pin_empty_g", g, 0);  chk("pin_empty_s", s, 2);
    predict(16'h0033, 0, g, s);  chk("pin_lim0_g", g, 0);   chk("pin_lim0_s", s, 1);
    predict(16'h0070, 10, g, s);
    chk("pin_blink_g", g, OSC ? 2 : 10);
    chk("pin_blink_s", s, OSC ? 4 : 1);

    run_model(16'h0033, 10, 1'b0);
    run_model(16'h0001, 10, 1'b0);
    run_model(16'h0000, 10, 1'b0);
    run_model(16'h0070, 10, 1'b0);
    run_model(16'h0033, 0, 1'b0);
    run_model(16'h0070, 10, 1'b1);

    for (int r = 0; r < 25; r++)
      run_model(16'($urandom), $urandom_range(0, 12), 1'b1);

    // Pause parked from the first CHECK, then single steps, then release.
    predict(16'h0070, 10, g, s);
    @(negedge clk);
    sp0 = step_pulses;
    pause = 1'b1; seeds = 16'h0070; gen_limit = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("park_busy", busy, 1);
    chk("park_done", done, 0);
    chk("park_gen", gen_count, 0);
    chk("park_steps", step_pulses - sp0, 0);
    for (int p = 0; p < 3; p++) begin
      single_step = 1'b1;
      @(negedge clk); single_step = 1'b0;
      repeat (5) @(negedge clk);
    end
    eg = (g < 3) ? g : 3;
    chk("sstep_gen", gen_count, eg);
    chk("sstep_steps", step_pulses - sp0, eg);
    chk("sstep_done", done, g <= 3);
    chk("sstep_busy", busy, g > 3);
    pause = 1'b0;
    wait_done(100);
    chk("resume_gen", gen_count, g);
    chk("resume_status", status, s);
    chk("resume_steps", step_pulses - sp0, g);

    // Abort mid-run.
    ab = OSC ? 1 : 4;
    @(negedge clk);
    seeds = 16'h0070; gen_limit = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60 && gen_count != 16'(ab); i++) @(negedge clk);
    chk("abort_reach", gen_count, ab);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_status", status, 0);
    chk("abort_gen", gen_count, ab);
    chk("abort_seeds", grid_seeds, 16'h0070);

    // start together with abort: abort wins.
    start = 1'b1; abort = 1'b1; seeds = 16'h0033;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_load", grid_load, 0);
    chk("sa_seeds", grid_seeds, 16'h0070);
    repeat (2) @(negedge clk);
    chk("sa_idle", busy, 0);

    // Reset during a STEP cycle.
    seeds = 16'h0070; gen_limit = 16'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !grid_step; i++) @(negedge clk);
    chk("rst_reach_step", grid_step, 1);
    nrst = 1'b0;
    @(negedge clk);
    chk("mrst_step", grid_step, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_gen", gen_count, 0);
    chk("mrst_status", status, 0);
    chk("mrst_seeds", grid_seeds, 0);
    nrst = 1'b1;
    @(negedge clk);

    run_model(16'h0033, 10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
